// File: rtl/speed_cmd_arbiter.sv
// Merges push-button and PS/2 command speed requests into a saturating target code,
// ramps the output code toward it one step per tick and selects speed/message display.
module speed_cmd_arbiter #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned STEP_HZ    = 4,
    parameter int unsigned REPEAT_MS  = 500,
    parameter int unsigned MSG_MS     = 2000,
    parameter int unsigned SPEED_MIN  = 0,
    parameter int unsigned SPEED_MAX  = 8,
    parameter int unsigned SPEED_INIT = 3
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        cmdValid,
    input  logic [15:0] cmdCode,
    output logic [3:0]  speedCode,
    output logic [3:0]  targetCode,
    output logic        ramping,
    output logic        dispSel,
    output logic [1:0]  msgCode,
    output logic        cmdAccept
);

    localparam int unsigned STEP_DIV   = CLK_FREQ / STEP_HZ;
    localparam int unsigned REPEAT_DIV = (CLK_FREQ / 1000) * REPEAT_MS;
    localparam int unsigned MSG_DIV    = (CLK_FREQ / 1000) * MSG_MS;

    localparam logic [3:0] SpdMin  = 4'(SPEED_MIN);
    localparam logic [3:0] SpdMax  = 4'(SPEED_MAX);
    localparam logic [3:0] SpdInit = 4'(SPEED_INIT);

    localparam logic [15:0] CodeFast = 16'h002B;
    localparam logic [15:0] CodeChup = 16'h0021;
    localparam logic [15:0] CodeSlid = 16'h001B;

    typedef enum logic [1:0] {StIdle, StPress, StRepeat} state_e;

    state_e      st_q;
    logic        active_up_q;
    logic [31:0] tick_q;
    logic [31:0] hold_q;
    logic [31:0] msg_tmr_q;
    logic        up_prev_q;
    logic        down_prev_q;
    logic [3:0]  speed_q;
    logic [3:0]  target_q;
    logic        disp_q;
    logic [1:0]  msg_q;
    logic        accept_q;

    logic        step_tick;
    logic        up_rise;
    logic        down_rise;
    logic        active_held;
    logic        btn_step;
    logic        btn_up_dir;
    logic        cmd_hit;
    logic [1:0]  cmd_msg;
    logic [3:0]  target_cmd;
    logic [3:0]  target_inc;
    logic [3:0]  target_dec;
    logic [3:0]  target_d;
    logic        accept_d;

    assign step_tick   = (tick_q == STEP_DIV - 1);
    assign up_rise     = btnUp & ~up_prev_q;
    assign down_rise   = btnDown & ~down_prev_q;
    assign active_held = active_up_q ? btnUp : btnDown;
    assign target_inc  = (target_q >= SpdMax) ? target_q : target_q + 4'd1;
    assign target_dec  = (target_q <= SpdMin) ? target_q : target_q - 4'd1;

    // Button step request; down wins a simultaneous press.
    always_comb begin
        btn_step   = 1'b0;
        btn_up_dir = 1'b0;
        case (st_q)
            StIdle: begin
                if (down_rise) begin
                    btn_step = 1'b1;
                end else if (up_rise) begin
                    btn_step   = 1'b1;
                    btn_up_dir = 1'b1;
                end
            end
            StRepeat: begin
                if (active_held && step_tick) begin
                    btn_step   = 1'b1;
                    btn_up_dir = active_up_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_hit    = 1'b0;
        cmd_msg    = 2'd0;
        target_cmd = target_q;
        if (cmdValid) begin
            case (cmdCode)
                CodeFast: begin
                    cmd_hit    = 1'b1;
                    cmd_msg    = 2'd1;
                    target_cmd = SpdMax;
                end
                CodeChup: begin
                    cmd_hit    = 1'b1;
                    cmd_msg    = 2'd2;
                    target_cmd = target_inc;
                end
                CodeSlid: begin
                    cmd_hit    = 1'b1;
                    cmd_msg    = 2'd3;
                    target_cmd = SpdMin;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        accept_d = cmd_hit & ~btn_step;
        if (btn_step) begin
            target_d = btn_up_dir ? target_inc : target_dec;
        end else if (cmd_hit) begin
            target_d = target_cmd;
        end else begin
            target_d = target_q;
        end
    end

    // Edge detectors reset high so a button held through reset must be re-pressed.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            st_q        <= StIdle;
            active_up_q <= 1'b0;
            tick_q      <= '0;
            hold_q      <= '0;
            msg_tmr_q   <= '0;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
            speed_q     <= SpdInit;
            target_q    <= SpdInit;
            disp_q      <= 1'b0;
            msg_q       <= 2'd0;
            accept_q    <= 1'b0;
        end else begin
            tick_q      <= step_tick ? 32'd0 : tick_q + 32'd1;
            up_prev_q   <= btnUp;
            down_prev_q <= btnDown;
            target_q    <= target_d;
            accept_q    <= accept_d;

            if (step_tick && (speed_q != target_q)) begin
                speed_q <= (speed_q < target_q) ? speed_q + 4'd1 : speed_q - 4'd1;
            end

            if (btn_step) begin
                disp_q <= 1'b0;
                msg_q  <= 2'd0;
            end else if (accept_d) begin
                disp_q    <= 1'b1;
                msg_q     <= cmd_msg;
                msg_tmr_q <= '0;
            end else if (disp_q) begin
                if (msg_tmr_q == MSG_DIV - 1) begin
                    disp_q <= 1'b0;
                    msg_q  <= 2'd0;
                end else begin
                    msg_tmr_q <= msg_tmr_q + 32'd1;
                end
            end

            case (st_q)
                StIdle: begin
                    if (up_rise || down_rise) begin
                        st_q        <= StPress;
                        active_up_q <= up_rise & ~down_rise;
                        hold_q      <= '0;
                    end
                end
                StPress: begin
                    if (!active_held) begin
                        st_q <= StIdle;
                    end else if (hold_q == REPEAT_DIV - 1) begin
                        st_q <= StRepeat;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
                end
                StRepeat: begin
                    if (!active_held) begin
                        st_q <= StIdle;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign speedCode  = speed_q;
    assign targetCode = target_q;
    assign ramping    = (speed_q != target_q);
    assign dispSel    = disp_q;
    assign msgCode    = msg_q;
    assign cmdAccept  = accept_q;

endmodule

// File: tb/tb_speed_cmd_arbiter.sv
// Self-checking bench: directed scenarios plus random stimulus, compared every cycle
// against an event-level model of the arbiter.
module tb_speed_cmd_arbiter;

    localparam int CLK_FREQ   = 1000;
    localparam int STEP_HZ    = 4;
    localparam int REPEAT_MS  = 500;
    localparam int MSG_MS     = 2000;
    localparam int STEP_DIV   = CLK_FREQ / STEP_HZ;
    localparam int REPEAT_DIV = (CLK_FREQ / 1000) * REPEAT_MS;
    localparam int MSG_DIV    = (CLK_FREQ / 1000) * MSG_MS;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        btnUp = 1'b0;
    logic        btnDown = 1'b0;
    logic        cmdValid = 1'b0;
    logic [15:0] cmdCode = 16'h0000;
    logic [3:0]  speedCode;
    logic [3:0]  targetCode;
    logic        ramping;
    logic        dispSel;
    logic [1:0]  msgCode;
    logic        cmdAccept;

    int tests = 0;
    int fails = 0;

    speed_cmd_arbiter #(
        .CLK_FREQ  (CLK_FREQ),
        .STEP_HZ   (STEP_HZ),
        .REPEAT_MS (REPEAT_MS),
        .MSG_MS    (MSG_MS),
        .SPEED_MIN (0),
        .SPEED_MAX (8),
        .SPEED_INIT(3)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .btnUp     (btnUp),
        .btnDown   (btnDown),
        .cmdValid  (cmdValid),
        .cmdCode   (cmdCode),
        .speedCode (speedCode),
        .targetCode(targetCode),
        .ramping   (ramping),
        .dispSel   (dispSel),
        .msgCode   (msgCode),
        .cmdAccept (cmdAccept)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: n counts clock edges since reset release; a tick falls on every
    // STEP_DIV-th edge. A press records its edge; auto-repeat steps on ticks after
    // REPEAT_DIV further edges of continuous hold.
    int m_n, m_spd, m_tgt, m_disp, m_msg, m_acc, m_deadline, m_n0;
    bit m_pu, m_pd, m_pressed, m_pup;

    task automatic model_reset();
        m_n = 0; m_spd = 3; m_tgt = 3; m_disp = 0; m_msg = 0; m_acc = 0;
        m_deadline = 0; m_n0 = 0; m_pu = 1; m_pd = 1; m_pressed = 0; m_pup = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit v, input logic [15:0] c);
        bit tick;
        int step;
        int hit_msg;
        int cmd_tgt;
        int old_tgt;
        m_n++;
        tick = (m_n % STEP_DIV) == 0;
        step = 0;
        if (!m_pressed) begin
            if (d && !m_pd) begin
                step = 2; m_pressed = 1; m_pup = 0; m_n0 = m_n;
            end else if (u && !m_pu) begin
                step = 1; m_pressed = 1; m_pup = 1; m_n0 = m_n;
            end
        end else if (!(m_pup ? u : d)) begin
            m_pressed = 0;
        end else if (tick && m_n > m_n0 + REPEAT_DIV) begin
            step = m_pup ? 1 : 2;
        end
        hit_msg = 0;
        cmd_tgt = m_tgt;
        if (v) begin
            if (c == 16'h002B) begin hit_msg = 1; cmd_tgt = 8; end
            else if (c == 16'h0021) begin hit_msg = 2; cmd_tgt = (m_tgt < 8) ? m_tgt + 1 : 8; end
            else if (c == 16'h001B) begin hit_msg = 3; cmd_tgt = 0; end
        end
        old_tgt = m_tgt;
        m_acc = (hit_msg != 0 && step == 0) ? 1 : 0;
        if (step == 1) m_tgt = (m_tgt < 8) ? m_tgt + 1 : 8;
        else if (step == 2) m_tgt = (m_tgt > 0) ? m_tgt - 1 : 0;
        else if (m_acc == 1) m_tgt = cmd_tgt;
        if (tick && m_spd != old_tgt) m_spd = (m_spd < old_tgt) ? m_spd + 1 : m_spd - 1;
        if (step != 0) begin
            m_disp = 0; m_msg = 0;
        end else if (m_acc == 1) begin
            m_disp = 1; m_msg = hit_msg; m_deadline = m_n + MSG_DIV;
        end else if (m_disp == 1 && m_n == m_deadline) begin
            m_disp = 0; m_msg = 0;
        end
        m_pu = u; m_pd = d;
    endtask

    function automatic int pack(input int s, input int t, input int r, input int ds,
                                input int ms, input int a);
        return (s << 9) | (t << 5) | (r << 4) | (ds << 3) | (ms << 1) | a;
    endfunction

    initial begin : compare
        model_reset();
        forever begin
            @(posedge clk);
            if (!rstN) model_reset();
            else model_step(btnUp, btnDown, cmdValid, cmdCode);
            #1;
            check("cycle {spd,tgt,ramp,disp,msg,acc}",
                  pack(int'(speedCode), int'(targetCode), int'(ramping), int'(dispSel),
                       int'(msgCode), int'(cmdAccept)),
                  pack(m_spd, m_tgt, (m_spd != m_tgt) ? 1 : 0, m_disp, m_msg, m_acc));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0; btnUp = 1'b0; btnDown = 1'b0; cmdValid = 1'b0; cmdCode = 16'h0;
        cycles(3);
        rstN = 1'b1;
        cycles(2);
    endtask

    task automatic send_cmd(input logic [15:0] code);
        cmdValid = 1'b1; cmdCode = code;
        @(negedge clk);
        cmdValid = 1'b0; cmdCode = 16'h0;
    endtask

    initial begin : stim
        int cnt;
        int s;
        cycles(2);
        check("rst speed", speedCode, 3);
        check("rst target", targetCode, 3);
        check("rst ramp/disp/msg/acc", {ramping, dispSel, msgCode, cmdAccept}, 0);
        rstN = 1'b1;
        cycles(5);

        // Short up press
        btnUp = 1'b1;
        @(negedge clk);
        check("up target", targetCode, 4);
        check("up ramping", ramping, 1);
        check("up speed hold", speedCode, 3);
        cycles(9);
        btnUp = 1'b0;
        for (int i = 0; i < 300 && speedCode != 4; i++) @(negedge clk);
        check("up speed", speedCode, 4);
        check("up ramp done", ramping, 0);

        // FAST command and message timeout
        do_reset();
        send_cmd(16'h002B);
        check("fast accept", cmdAccept, 1);
        check("fast msg", msgCode, 1);
        check("fast disp", dispSel, 1);
        check("fast target", targetCode, 8);
        cnt = 0;
        @(negedge clk);
        cnt++;
        check("fast accept pulse", cmdAccept, 0);
        while (cnt < 2100 && dispSel == 1'b1) begin
            @(negedge clk);
            cnt++;
        end
        check("fast disp hold cycles", cnt, 2000);
        check("fast msg cleared", msgCode, 0);
        check("fast speed", speedCode, 8);

        // Held down: immediate step, auto-repeat, saturate at 0
        do_reset();
        btnDown = 1'b1;
        @(negedge clk);
        check("down first", targetCode, 2);
        cycles(1999);
        check("down sat target", targetCode, 0);
        check("down sat speed", speedCode, 0);
        btnDown = 1'b0;

        // Simultaneous up/down/CHUP: down step wins, command dropped
        do_reset();
        btnUp = 1'b1; btnDown = 1'b1; cmdValid = 1'b1; cmdCode = 16'h0021;
        @(negedge clk);
        btnUp = 1'b0; btnDown = 1'b0; cmdValid = 1'b0; cmdCode = 16'h0;
        check("both target", targetCode, 2);
        check("both accept", cmdAccept, 0);
        check("both disp", dispSel, 0);

        // Unknown code, then SLID during ramp to 8
        cycles(2);
        send_cmd(16'h0015);
        check("unk accept", cmdAccept, 0);
        check("unk target", targetCode, 2);
        send_cmd(16'h002B);
        for (int i = 0; i < 2000 && speedCode != 5; i++) @(negedge clk);
        check("slid pre speed", speedCode, 5);
        send_cmd(16'h001B);
        check("slid target", targetCode, 0);
        check("slid msg", msgCode, 3);
        s = int'(speedCode);
        for (int i = 0; i < 300 && int'(speedCode) == s; i++) @(negedge clk);
        check("slid reverse", speedCode, s - 1);

        // Reset mid-ramp with btnUp held
        do_reset();
        btnUp = 1'b1;
        cycles(300);
        rstN = 1'b0;
        #1;
        check("midrst outputs", {speedCode, targetCode, ramping, dispSel, msgCode},
              {4'd3, 4'd3, 4'd0});
        cycles(2);
        rstN = 1'b1;
        cycles(600);
        check("held after rst target", targetCode, 3);
        check("held after rst speed", speedCode, 3);
        btnUp = 1'b0;
        @(negedge clk);
        btnUp = 1'b1;
        @(negedge clk);
        check("repress target", targetCode, 4);
        btnUp = 1'b0;

        // Random traffic
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 999) < 3) btnUp = ~btnUp;
            if ($urandom_range(0, 999) < 3) btnDown = ~btnDown;
            if ($urandom_range(0, 99) < 2) begin
                cmdValid = 1'b1;
                case ($urandom_range(0, 4))
                    0: cmdCode = 16'h002B;
                    1: cmdCode = 16'h0021;
                    2: cmdCode = 16'h001B;
                    3: cmdCode = 16'h0015;
                    default: cmdCode = 16'($urandom);
                endcase
            end else begin
                cmdValid = 1'b0;
                cmdCode = 16'h0;
            end
            @(negedge clk);
        end
        cmdValid = 1'b0;
        cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/speed_cmd_arbiter.md
# speed_cmd_arbiter

Arbitrates speed requests from the two debounced push-buttons and from decoded PS/2 keyboard commands into a single saturating target speed code. Ramps the output speed code toward that target one step per step tick. Also selects whether the right-hand 7-segment display shows the speed or a command message. Sits between the button debouncers / PS/2 receiver and the speed-to-7-segment decoder, replacing direct button-to-speed stepping.

## Interface
Parameters:
- CLK_FREQ, 100_000_000 — clk frequency in Hz.
- STEP_HZ, 4 — ramp/auto-repeat tick rate; STEP_DIV = CLK_FREQ/STEP_HZ cycles.
- REPEAT_MS, 500 — hold time before auto-repeat; REPEAT_DIV = (CLK_FREQ/1000)*REPEAT_MS cycles.
- MSG_MS, 2000 — message display hold; MSG_DIV = (CLK_FREQ/1000)*MSG_MS cycles.
- SPEED_MIN, 0 — lowest code (120).
- SPEED_MAX, 8 — highest code (160).
- SPEED_INIT, 3 — reset code (135).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- btnUp  in  1  debounced up request, active-high level, synchronous to clk.
- btnDown  in  1  debounced down request, active-high level, synchronous to clk.
- cmdValid  in  1  one-cycle strobe: cmdCode is a new completed scan code.
- cmdCode  in  16  PS/2 scan code {byte2, byte1}.
- speedCode  out  4  current (ramped) speed code, registered.
- targetCode  out  4  requested speed code, registered.
- ramping  out  1  speedCode != targetCode.
- dispSel  out  1  0 = show speed, 1 = show message.
- msgCode  out  2  0 none, 1 FAST, 2 CHUP, 3 SLID.
- cmdAccept  out  1  one-cycle pulse: command decoded and applied.

## Operation
- Reset (rstN low, asynchronous): speedCode = targetCode = SPEED_INIT, ramping 0, dispSel 0, msgCode 0, cmdAccept 0. All counters 0, button FSMs IDLE.
- Tick generator: free-running counter 0..STEP_DIV-1. stepTick is high for one cycle when the count equals STEP_DIV-1.
- Button FSM (one shared): IDLE, PRESS, REPEAT.
  - IDLE: rising edge of btnDown or btnUp (prev 0, now 1) → apply one step, clear hold counter, go to PRESS.
  - PRESS: the active button is held → count cycles. At REPEAT_DIV-1 → REPEAT. Release → IDLE.
  - REPEAT: the active button is held → one step per stepTick. Release → IDLE.
  - The active button is latched on entry to PRESS. Pressing the other button while in PRESS/REPEAT is ignored until return to IDLE.
- Step: up → targetCode+1, saturating at SPEED_MAX. Down → targetCode-1, saturating at SPEED_MIN.
- Both rising edges in the same cycle: down wins.
- PS/2 commands on a cmdValid strobe:
  - 16'h002B FAST → targetCode = SPEED_MAX, msgCode 1.
  - 16'h0021 CHUP → targetCode+1 saturating, msgCode 2.
  - 16'h001B SLID → targetCode = SPEED_MIN, msgCode 3.
  - Any other code is ignored, with no cmdAccept.
- Priority: a button step in the same cycle as a cmdValid wins. That command is dropped, with cmdAccept 0.
- Ramp: on each stepTick with speedCode != targetCode, speedCode moves exactly one code toward targetCode. It never overshoots and never changes without a tick.
- Display:
  - Accepted command → dispSel 1, message timer reloads to 0.
  - Timer reaching MSG_DIV-1 → dispSel 0, msgCode 0.
  - A new accepted command restarts the timer.
  - Any button step forces dispSel 0 and msgCode 0 in the same update.

## Timing
- Button rising edge sampled at edge N → targetCode updated at edge N+1.
- Accepted command: cmdValid high at edge N → targetCode, msgCode, dispSel and the cmdAccept pulse all take effect at edge N+1. cmdAccept stays high for exactly one cycle.
- speedCode changes only on the edge where stepTick is high. Worst-case start latency is STEP_DIV cycles; a full 0→8 ramp takes 8 ticks.
- First auto-repeat step occurs on the first stepTick after REPEAT_DIV cycles of continuous hold.
- ramping is combinational from the registered codes, so it has zero latency.
- rstN asserted mid-ramp or mid-hold → immediate return to reset values. After rstN release, a still-held button does not step until it is released and pressed again.

## Test plan
Bench parameters: CLK_FREQ=1000, STEP_HZ=4 (STEP_DIV=250), REPEAT_MS=500, MSG_MS=2000.
- Reset, then a 10-cycle btnUp pulse → targetCode 4 one cycle after the edge. speedCode 3→4 on the next stepTick. ramping 1→0.
- cmdValid with cmdCode=16'h002B → cmdAccept one pulse, msgCode 1, dispSel 1, targetCode 8. speedCode steps 3,4,…,8 on 5 consecutive ticks. dispSel falls 2000 cycles after the accept.
- btnDown held 2000 cycles from code 3 → immediate step to 2. After 500 cycles, one step per tick, saturating at 0 with no underflow.
- btnUp and btnDown rising in the same cycle, plus cmdValid 16'h0021 in that cycle → targetCode 2, cmdAccept 0, dispSel 0.
- Unknown code 16'h0015 → no change, no cmdAccept. Then SLID during a ramp toward 8 → target 0, and the ramp reverses on the next tick.
- rstN low mid-ramp with btnUp held, then release → outputs back to 3/3/0/0/0. No step until btnUp toggles low→high.
